// File: rtl/wb_tpm_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// wb_tpm_mailbox_pkg
//   Shared definitions for the M4-side TPM mailbox: register offsets,
//   CTRL/STATUS bit positions, FSM state encoding and a STATUS packing helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package wb_tpm_mailbox_pkg;

    // Wishbone access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } mbox_state_t;

    // Register word offsets (WBs_ADR[3:2] when WBs_ADR[11]=1)
    localparam logic [1:0] REG_STATUS     = 2'd0;
    localparam logic [1:0] REG_CTRL       = 2'd1;
    localparam logic [1:0] REG_IRQ_EN     = 2'd2;
    localparam logic [1:0] REG_CMD_CYCLES = 2'd3;

    // CTRL write-1 pulse bits
    localparam int CTRL_COMPLETE  = 0;
    localparam int CTRL_CMD_CLR   = 1;
    localparam int CTRL_ABORT_CLR = 2;

    // STATUS bit positions
    localparam int STAT_CMD_PEND   = 0;
    localparam int STAT_ABORT_PEND = 1;
    localparam int STAT_COMPLETE   = 2;
    localparam int STAT_EXEC_SYNC  = 3;

    // Command timer saturation value
    localparam logic [23:0] CMD_CYCLES_MAX = 24'hFF_FFFF;

    // Pack the STATUS register word from its individual flags
    function automatic logic [31:0] status_word(
        input logic cmd_pend,
        input logic abort_pend,
        input logic complete,
        input logic exec_sync
    );
        logic [31:0] word;
        word = 32'h0000_0000;
        word[STAT_CMD_PEND]   = cmd_pend;
        word[STAT_ABORT_PEND] = abort_pend;
        word[STAT_COMPLETE]   = complete;
        word[STAT_EXEC_SYNC]  = exec_sync;
        return word;
    endfunction

endpackage

// File: rtl/wb_tpm_mailbox_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//   STAGES-deep single-bit synchronizer, flops cleared by synchronous reset.
//   Ports:
//     clk  in  1  destination clock
//     rst  in  1  synchronous active-high reset
//     d    in  1  asynchronous input level
//     q    out 1  synchronized level
// ---------------------------------------------------------------------------
module sync_ff
    import wb_tpm_mailbox_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous level through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/wb_tpm_mailbox.sv
// ---------------------------------------------------------------------------
// wb_tpm_mailbox
//   M4-side consumer of the TPM register block command handshake. Wishbone
//   slave that synchronizes exec/abort, latches them as sticky pending flags,
//   raises a level interrupt, drives the complete handshake back and maps the
//   512x32 command buffer into M4 address space.
//
//   Optional feature macro: WB_MBOX_CMD_TIMER_EN (24-bit command cycle timer
//   readable through CMD_CYCLES; when undefined CMD_CYCLES reads 0).
//
//   Ports:
//     WB_CLK        in  1   sole clock
//     WB_RST        in  1   synchronous active-high reset
//     WBs_ADR       in  17  byte address
//     WBs_CYC/STB   in  1   Wishbone cycle / strobe
//     WBs_WE        in  1   1 = write
//     WBs_BYTE_STB  in  4   byte enables (buffer writes only)
//     WBs_WR_DAT    in  32  write data
//     WBs_RD_DAT    out 32  read data, valid while WBs_ACK=1
//     WBs_ACK       out 1   single-cycle acknowledge
//     exec_i        in  1   async command-ready level
//     abort_i       in  1   async abort-request level
//     complete_o    out 1   command-finished level
//     ram_*         -       command buffer port (addr/wdata/byte wen/wr/rd strobes/rdata)
//     irq_o         out 1   level interrupt to M4
// ---------------------------------------------------------------------------
module wb_tpm_mailbox
    import wb_tpm_mailbox_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR   = 5'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        WB_CLK,
    input  logic        WB_RST,
    input  logic [16:0] WBs_ADR,
    input  logic        WBs_CYC,
    input  logic        WBs_STB,
    input  logic        WBs_WE,
    input  logic [3:0]  WBs_BYTE_STB,
    input  logic [31:0] WBs_WR_DAT,
    output logic [31:0] WBs_RD_DAT,
    output logic        WBs_ACK,
    input  logic        exec_i,
    input  logic        abort_i,
    output logic        complete_o,
    output logic [8:0]  ram_addr_o,
    output logic [31:0] ram_wd_o,
    output logic [3:0]  ram_wen_o,
    output logic        ram_wr_en_o,
    output logic        ram_rd_en_o,
    input  logic [31:0] ram_rd_i,
    output logic        irq_o
);

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic exec_sync_s;
    logic abort_sync_s;
    logic exec_prev_r;
    logic abort_prev_r;
    logic exec_rise_s;
    logic exec_fall_s;
    logic abort_rise_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_exec_sync (
        .clk (WB_CLK),
        .rst (WB_RST),
        .d   (exec_i),
        .q   (exec_sync_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_abort_sync (
        .clk (WB_CLK),
        .rst (WB_RST),
        .d   (abort_i),
        .q   (abort_sync_s)
    );

    // Previous synchronized levels; cleared in reset so a level held high
    // through reset is seen as a fresh rising edge afterwards
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            exec_prev_r  <= 1'b0;
            abort_prev_r <= 1'b0;
        end else begin
            exec_prev_r  <= exec_sync_s;
            abort_prev_r <= abort_sync_s;
        end
    end

    assign exec_rise_s  = exec_sync_s  & ~exec_prev_r;
    assign exec_fall_s  = ~exec_sync_s & exec_prev_r;
    assign abort_rise_s = abort_sync_s & ~abort_prev_r;

    // ------------------------------------------------------------------
    // Address decode and access sequencer
    // ------------------------------------------------------------------
    mbox_state_t state_r;
    mbox_state_t next_state_s;
    logic        hit_s;
    logic        buf_sel_s;
    logic [1:0]  reg_idx_s;
    logic        take_s;
    logic        buf_wr_s;
    logic        buf_rd_s;
    logic        reg_wr_s;
    logic        reg_rd_s;
    logic        ack_r;
    logic [31:0] rd_dat_r;
    logic [31:0] reg_rdata_s;
    logic        unused_ok_s;

    assign hit_s     = WBs_CYC & WBs_STB & (WBs_ADR[16:12] == BASE_ADDR);
    assign buf_sel_s = ~WBs_ADR[11];
    assign reg_idx_s = WBs_ADR[3:2];

    // Byte-lane bits are not part of any decode
    assign unused_ok_s = ^WBs_ADR[1:0];

    // Next-state logic; a request is only taken in IDLE, never in ACK
    always_comb begin
        next_state_s = state_r;
        take_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s && !WB_RST) begin
                    take_s = 1'b1;
                    if (buf_sel_s && !WBs_WE) begin
                        next_state_s = ST_RD_WAIT;
                    end else begin
                        next_state_s = ST_ACK;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: next_state_s = ST_ACK;
            ST_ACK:     next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    assign buf_wr_s = take_s & buf_sel_s & WBs_WE;
    assign buf_rd_s = take_s & buf_sel_s & ~WBs_WE;
    assign reg_wr_s = take_s & ~buf_sel_s & WBs_WE;
    assign reg_rd_s = take_s & ~buf_sel_s & ~WBs_WE;

    // The buffer port is driven in the strobe cycle itself so the RAM samples
    // the request on the same edge the sequencer leaves IDLE; this is what
    // gives the 2-cycle write / 3-cycle read acknowledge latency.
    assign ram_wr_en_o = buf_wr_s;
    assign ram_rd_en_o = buf_rd_s;
    assign ram_addr_o  = (buf_wr_s | buf_rd_s) ? WBs_ADR[10:2] : 9'd0;
    assign ram_wd_o    = buf_wr_s ? WBs_WR_DAT : 32'h0000_0000;
    assign ram_wen_o   = buf_wr_s ? WBs_BYTE_STB : 4'b0000;

    // Sequencer state register
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Acknowledge and read data are registered so they are high exactly
    // during the ACK state; read data returns to 0 outside it
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            ack_r    <= 1'b0;
            rd_dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= (next_state_s == ST_ACK);
            if (reg_rd_s) begin
                rd_dat_r <= reg_rdata_s;
            end else if (state_r == ST_RD_WAIT) begin
                rd_dat_r <= ram_rd_i;
            end else begin
                rd_dat_r <= 32'h0000_0000;
            end
        end
    end

    assign WBs_ACK    = ack_r;
    assign WBs_RD_DAT = rd_dat_r;

    // ------------------------------------------------------------------
    // Flags, handshake and interrupt
    // ------------------------------------------------------------------
    logic       cmd_pend_r;
    logic       abort_pend_r;
    logic       complete_r;
    logic [1:0] irq_en_r;
    logic       irq_r;
    logic       ctrl_wr_s;
    logic       ctrl_complete_s;
    logic       ctrl_cmd_clr_s;
    logic       ctrl_abort_clr_s;
    logic       irq_en_wr_s;
    logic [31:0] cmd_cycles_s;

    assign ctrl_wr_s        = reg_wr_s & (reg_idx_s == REG_CTRL);
    assign ctrl_complete_s  = ctrl_wr_s & WBs_WR_DAT[CTRL_COMPLETE];
    assign ctrl_cmd_clr_s   = ctrl_wr_s & WBs_WR_DAT[CTRL_CMD_CLR];
    assign ctrl_abort_clr_s = ctrl_wr_s & WBs_WR_DAT[CTRL_ABORT_CLR];
    assign irq_en_wr_s      = reg_wr_s & (reg_idx_s == REG_IRQ_EN);

    // Sticky pending flags; a new edge beats a simultaneous clear
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            cmd_pend_r   <= 1'b0;
            abort_pend_r <= 1'b0;
        end else begin
            if (exec_rise_s) begin
                cmd_pend_r <= 1'b1;
            end else if (ctrl_complete_s || ctrl_cmd_clr_s) begin
                cmd_pend_r <= 1'b0;
            end else begin
                cmd_pend_r <= cmd_pend_r;
            end
            if (abort_rise_s) begin
                abort_pend_r <= 1'b1;
            end else if (ctrl_abort_clr_s) begin
                abort_pend_r <= 1'b0;
            end else begin
                abort_pend_r <= abort_pend_r;
            end
        end
    end

    // Four-phase complete: raised only while exec is still asserted,
    // dropped once exec goes away
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            complete_r <= 1'b0;
        end else if (ctrl_complete_s && exec_sync_s) begin
            complete_r <= 1'b1;
        end else if (exec_fall_s) begin
            complete_r <= 1'b0;
        end else begin
            complete_r <= complete_r;
        end
    end

    // Interrupt enable register and registered interrupt level
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            irq_en_r <= 2'b00;
            irq_r    <= 1'b0;
        end else begin
            if (irq_en_wr_s) begin
                irq_en_r <= WBs_WR_DAT[1:0];
            end else begin
                irq_en_r <= irq_en_r;
            end
            irq_r <= |({abort_pend_r, cmd_pend_r} & irq_en_r);
        end
    end

    assign complete_o = complete_r;
    assign irq_o      = irq_r;

    // ------------------------------------------------------------------
    // Optional command cycle timer
    // ------------------------------------------------------------------
`ifdef WB_MBOX_CMD_TIMER_EN
    logic [23:0] cmd_count_r;

    // Counts cycles from exec rise until complete, saturating
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            cmd_count_r <= 24'h00_0000;
        end else if (exec_rise_s) begin
            cmd_count_r <= 24'h00_0000;
        end else if (exec_sync_s && !complete_r && (cmd_count_r != CMD_CYCLES_MAX)) begin
            cmd_count_r <= cmd_count_r + 24'h00_0001;
        end else begin
            cmd_count_r <= cmd_count_r;
        end
    end

    assign cmd_cycles_s = {8'h00, cmd_count_r};
`else
    assign cmd_cycles_s = 32'h0000_0000;
`endif

    // Register read mux
    always_comb begin
        reg_rdata_s = 32'h0000_0000;
        case (reg_idx_s)
            REG_STATUS:     reg_rdata_s = status_word(cmd_pend_r, abort_pend_r, complete_r, exec_sync_s);
            REG_CTRL:       reg_rdata_s = 32'h0000_0000;
            REG_IRQ_EN:     reg_rdata_s = {30'd0, irq_en_r};
            REG_CMD_CYCLES: reg_rdata_s = cmd_cycles_s;
            default:        reg_rdata_s = 32'h0000_0000;
        endcase
    end

endmodule
